// File: rtl/axis_frame_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_chk_pkg
// Description : Shared constants for the AXI4-Stream frame checker:
//               FSM state encoding, counter/position widths and the
//               saturation limit of the error counters.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_chk_pkg;

  localparam int CNT_W = 16;   // error / frame counter width
  localparam int POS_W = 12;   // pixel-in-line and line-in-frame width

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_RECV     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/axis_frame_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_checker_if
// Description : 64-bit AXI4-Stream video bus (tdata/tvalid/tready/tuser/tlast).
//               tuser marks start of frame, tlast marks end of line.
//   modport master : drives tdata, tvalid, tuser, tlast; samples tready
//   modport slave  : samples tdata, tvalid, tuser, tlast; drives tready
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_frame_checker_if;

  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast,
                  input  tready);

  modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast,
                  output tready);

endinterface
`default_nettype wire

// File: rtl/axis_frame_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : CNT_W-bit up counter that sticks at CNT_MAX. A clear in the
//               same cycle as an increment leaves the counter at 1 so the
//               coincident event is not lost.
//   clk   in  clock
//   reset in  synchronous active-high reset
//   inc   in  count one event
//   clr   in  zero the counter
//   count out current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import axis_chk_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             inc,
  input  wire logic             clr,
  output logic [CNT_W-1:0]      count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_checker
// Description : AXI4-Stream video sink. Tracks pixel/line position from
//               tuser (SOF) and tlast (EOL), pulses frame_done per complete
//               frame and keeps saturating framing/data error counters.
//   clk, reset        clock, synchronous active-high reset
//   enable            level; low parks the block in IDLE (sampled in WAIT_SOF)
//   clr               pulse; zeroes all counters
//   s_axis            stream input (slave modport)
//   frame_done        one-cycle pulse per completed frame
//   frame_count       completed frames (saturating)
//   err_sof           unexpected SOF inside a frame
//   err_eol_early     tlast before the last pixel of a line
//   err_eol_late      missing tlast on the last pixel of a line
//   err_data          tdata != EXPECT_WORD
//   busy              high while receiving a frame
// Build option: define AXIS_CHK_DATA_EN to build the tdata comparator;
//               otherwise err_data stays 0 and tdata is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_checker
  import axis_chk_pkg::*;
#(
  parameter int          COL         = 1024,
  parameter int          ROWS        = 1,
  parameter logic [63:0] EXPECT_WORD = 64'h399784ec
) (
  input  wire logic           clk,
  input  wire logic           reset,
  input  wire logic           enable,
  input  wire logic           clr,
  axis_frame_checker_if.slave s_axis,
  output logic                frame_done,
  output logic [CNT_W-1:0]    frame_count,
  output logic [CNT_W-1:0]    err_sof,
  output logic [CNT_W-1:0]    err_eol_early,
  output logic [CNT_W-1:0]    err_eol_late,
  output logic [CNT_W-1:0]    err_data,
  output logic                busy
);

  logic [1:0]       state, state_n;
  logic [POS_W-1:0] pixel, pixel_n;
  logic [POS_W-1:0] line, line_n, line_base;
  logic             accept;
  logic             line_end;
  logic             inc_frame, inc_sof, inc_early, inc_late, inc_data;

  // Ready depends on registered state only, so the source never sees a
  // combinational path from its own tvalid.
  assign s_axis.tready = (state != ST_IDLE);
  assign busy          = (state == ST_RECV);
  assign accept        = s_axis.tvalid && s_axis.tready;

  always_comb begin
    state_n   = state;
    pixel_n   = pixel;
    line_n    = line;
    line_base = line;
    line_end  = 1'b0;
    inc_frame = 1'b0;
    inc_sof   = 1'b0;
    inc_early = 1'b0;
    inc_late  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) state_n = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        // A handshaked SOF beat is consumed even if enable just dropped;
        // enable then takes effect at the next frame boundary.
        if (accept && s_axis.tuser) begin
          state_n   = ST_RECV;
          pixel_n   = POS_W'(1);
          line_n    = '0;
          line_base = '0;
          if (s_axis.tlast) begin
            inc_early = 1'b1;
            line_end  = 1'b1;
          end
        end else if (!enable) begin
          state_n = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (accept) begin
          if (s_axis.tuser) begin
            // Resync: the SOF beat starts a fresh frame at pixel 0, line 0.
            inc_sof   = 1'b1;
            pixel_n   = POS_W'(1);
            line_n    = '0;
            line_base = '0;
            if (s_axis.tlast) begin
              inc_early = 1'b1;
              line_end  = 1'b1;
            end
          end else if (pixel == POS_W'(COL - 1)) begin
            line_end = 1'b1;
            inc_late = !s_axis.tlast;
          end else if (s_axis.tlast) begin
            inc_early = 1'b1;
            line_end  = 1'b1;
          end else begin
            pixel_n = pixel + POS_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (line_end) begin
      pixel_n = '0;
      line_n  = line_base + POS_W'(1);
      if (line_n == POS_W'(ROWS)) begin
        inc_frame = 1'b1;
        line_n    = '0;
        state_n   = ST_WAIT_SOF;
      end
    end
  end

`ifdef AXIS_CHK_DATA_EN
  assign inc_data = accept && (s_axis.tdata != EXPECT_WORD) &&
                    ((state == ST_RECV) || ((state == ST_WAIT_SOF) && s_axis.tuser));
`else
  logic unused_data;
  assign inc_data    = 1'b0;
  assign unused_data = ^{s_axis.tdata, EXPECT_WORD};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pixel      <= '0;
      line       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      pixel      <= pixel_n;
      line       <= line_n;
      frame_done <= inc_frame;
    end
  end

  sat_counter u_frame_cnt (.clk(clk), .reset(reset), .inc(inc_frame), .clr(clr), .count(frame_count));
  sat_counter u_sof_cnt   (.clk(clk), .reset(reset), .inc(inc_sof),   .clr(clr), .count(err_sof));
  sat_counter u_early_cnt (.clk(clk), .reset(reset), .inc(inc_early), .clr(clr), .count(err_eol_early));
  sat_counter u_late_cnt  (.clk(clk), .reset(reset), .inc(inc_late),  .clr(clr), .count(err_eol_late));
  sat_counter u_data_cnt  (.clk(clk), .reset(reset), .inc(inc_data),  .clr(clr), .count(err_data));

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_checker
// Description : Directed self-checking bench for axis_frame_checker with
//               COL=4, ROWS=2 (8-beat frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_checker;

  localparam int          COL  = 4;
  localparam int          ROWS = 2;
  localparam logic [63:0] EXP  = 64'h399784ec;
`ifdef AXIS_CHK_DATA_EN
  localparam logic [15:0] DATA_ERR_EXP = 16'd1;
`else
  localparam logic [15:0] DATA_ERR_EXP = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic        frame_done, busy;
  logic [15:0] frame_count, err_sof, err_eol_early, err_eol_late, err_data;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit chk_rdy = 1'b0;

  axis_frame_checker_if bus ();

  axis_frame_checker #(.COL(COL), .ROWS(ROWS), .EXPECT_WORD(EXP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr), .s_axis(bus),
    .frame_done(frame_done), .frame_count(frame_count), .err_sof(err_sof),
    .err_eol_early(err_eol_early), .err_eol_late(err_eol_late),
    .err_data(err_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input logic [15:0] fc, input logic [15:0] sof,
                            input logic [15:0] early, input logic [15:0] late,
                            input logic [15:0] data);
    chk({tag, "_frame_count"}, frame_count, fc);
    chk({tag, "_err_sof"}, err_sof, sof);
    chk({tag, "_err_eol_early"}, err_eol_early, early);
    chk({tag, "_err_eol_late"}, err_eol_late, late);
    chk({tag, "_err_data"}, err_data, data);
  endtask

  // Idle `gap` cycles, then present one beat and hold it until accepted.
  task automatic beat(input logic [63:0] d, input logic u, input logic l,
                      input int gap, input logic c);
    int w;
    repeat (gap) begin
      bus.tvalid = 1'b0;
      @(posedge clk); #1;
      if (chk_rdy) chk("tready_gap", bus.tready, 1);
    end
    bus.tdata = d; bus.tuser = u; bus.tlast = l; bus.tvalid = 1'b1; clr = c;
    w = 0;
    @(negedge clk);
    while (!bus.tready && w < 20) begin @(negedge clk); w++; end
    chk("handshake", bus.tready, 1);
    @(posedge clk); #1;
    bus.tvalid = 1'b0; bus.tuser = 1'b0; bus.tlast = 1'b0; clr = 1'b0;
  endtask

  // Clean 8-beat frame: SOF on beat 0, EOL on beats 3 and 7.
  task automatic frame8(input int gapmax, input bit clr_last);
    for (int i = 0; i < 8; i++) begin
      beat(EXP, i == 0, (i == 3) || (i == 7), $urandom_range(0, gapmax), clr_last && (i == 7));
      if (i == 6) chk("fd_before_end", frame_done, 0);
      if (i == 7) chk("fd_at_end", frame_done, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tdata = '0; bus.tvalid = 1'b0; bus.tuser = 1'b0; bus.tlast = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", bus.tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk_counts("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_tready", bus.tready, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("wait_sof_tready", bus.tready, 1);
    chk("wait_sof_busy", busy, 0);

    // Clean frame
    frame8(0, 1'b0);
    chk_counts("clean", 1, 0, 0, 0, 0);
    chk("clean_busy_after", busy, 0);
    @(posedge clk); #1;
    chk("clean_fd_drop", frame_done, 0);
    chk("clean_pulses", pulses, 1);

    // Same frame with random tvalid gaps; tready must stay high
    chk_rdy = 1'b1;
    frame8(3, 1'b0);
    chk_rdy = 1'b0;
    chk_counts("gaps", 2, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("gaps_pulses", pulses, 2);

    // Early tlast on beat 2
    beat(EXP, 1, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 1, 0, 0);
    chk("early_cnt_now", err_eol_early, 1);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    chk("early_fd_before", frame_done, 0);
    beat(EXP, 0, 1, 0, 0);
    chk("early_fd_end", frame_done, 1);
    chk_counts("early", 3, 0, 1, 0, 0);

    // Missing tlast on beat 3 (back-to-back after previous frame)
    beat(EXP, 1, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    chk("late_cnt_now", err_eol_late, 1);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 1, 0, 0);
    chk("late_fd_end", frame_done, 1);
    chk_counts("late", 4, 0, 1, 1, 0);

    // clr coincident with the frame-completing beat leaves frame_count at 1
    frame8(0, 1'b1);
    chk_counts("clr_inc", 1, 0, 0, 0, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_counts("clr_only", 0, 0, 0, 0, 0);

    // SOF re-asserted on beat 5; the resynced frame is the only one counted
    beat(EXP, 1, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(EXP, 0, 1, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    frame8(0, 1'b0);
    chk_counts("resync", 1, 1, 0, 0, 0);

    // Bad tdata on beat 2, then reset mid-frame
    beat(EXP, 1, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    beat(64'd0, 0, 0, 0, 0);
    beat(EXP, 0, 1, 0, 0);
    chk_counts("data", 1, 1, 0, 0, DATA_ERR_EXP);
    beat(EXP, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tready", bus.tready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fd", frame_done, 0);
    chk_counts("midrst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postrst_tready", bus.tready, 1);

    // enable dropped mid-frame: frame still completes, then IDLE
    beat(EXP, 1, 0, 0, 0);
    beat(EXP, 0, 0, 0, 0);
    enable = 1'b0;
    for (int i = 2; i < 8; i++) beat(EXP, 0, (i == 3) || (i == 7), 0, 0);
    chk_counts("dis", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("dis_tready", bus.tready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
